// File: rtl/alu_mdu_if.sv
// Handshake bundle between the EX-stage control and the alu_mdu arithmetic unit.
// The master side issues operations and consumes results; the slave is the unit.
interface alu_mdu_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      alu_op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            out_zero;

  modport master (
    output flush, in_valid, alu_op, a, b, pc, out_ready,
    input  in_ready, out_valid, out_result, out_zero
  );

  modport slave (
    input  flush, in_valid, alu_op, a, b, pc, out_ready,
    output in_ready, out_valid, out_result, out_zero
  );
endinterface

// File: rtl/alu_mdu.sv
// Execute-stage arithmetic unit: single-cycle integer ALU plus an iterative
// RV32M multiply (radix-2 shift-add) and divide (restoring radix-2) engine.
// Every result is registered together with its zero flag and held in DONE
// until the consumer takes it.
module alu_mdu #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input logic       clk,
  input logic       rst,
  alu_mdu_if.slave  bus
);

  localparam logic [4:0] OP_NOP    = 5'h00;
  localparam logic [4:0] OP_LUI    = 5'h01;
  localparam logic [4:0] OP_AUIPC  = 5'h02;
  localparam logic [4:0] OP_ADD    = 5'h03;
  localparam logic [4:0] OP_SUB    = 5'h04;
  localparam logic [4:0] OP_SLT    = 5'h05;
  localparam logic [4:0] OP_SLTU   = 5'h06;
  localparam logic [4:0] OP_XOR    = 5'h07;
  localparam logic [4:0] OP_OR     = 5'h08;
  localparam logic [4:0] OP_AND    = 5'h09;
  localparam logic [4:0] OP_SLL    = 5'h0A;
  localparam logic [4:0] OP_SRL    = 5'h0B;
  localparam logic [4:0] OP_SRA    = 5'h0C;
  localparam logic [4:0] OP_MUL    = 5'h10;
  localparam logic [4:0] OP_MULH   = 5'h11;
  localparam logic [4:0] OP_MULHSU = 5'h12;
  localparam logic [4:0] OP_MULHU  = 5'h13;
  localparam logic [4:0] OP_DIV    = 5'h14;
  localparam logic [4:0] OP_DIVU   = 5'h15;
  localparam logic [4:0] OP_REM    = 5'h16;
  localparam logic [4:0] OP_REMU   = 5'h17;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [SHW-1:0]  CNT_LAST = SHW'(XLEN - 1);
  localparam logic [SHW-1:0]  CNT_ONE  = SHW'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [4:0]        op_q, op_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic              mcorr_q, mcorr_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic [XLEN-1:0]   out_result_q, out_result_d;
  logic              out_zero_q, out_zero_d;
  logic              out_valid_q, out_valid_d;

  logic              accept_s, is_mop_s, is_div_s, sdiv_s, special_s;
  logic [XLEN-1:0]   special_res_s, imm_res_s, mag_a_s, mag_b_s;
  logic [2*XLEN-1:0] setup_acc_s, setup_mcand_s;
  logic [XLEN-1:0]   setup_mplier_s;
  logic              setup_mcorr_s, setup_qneg_s, setup_rneg_s;
  logic [XLEN:0]     div_top_s;
  logic              div_ge_s;
  logic [XLEN-1:0]   div_rem_s, quo_s, rem_s, final_res_s;
  logic [2*XLEN-1:0] iter_s, prod_s;

  function automatic logic [XLEN-1:0] base_alu(input logic [4:0] op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b,
                                                input logic [XLEN-1:0] pc);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (op)
      OP_NOP:   return a;
      OP_LUI:   return b;
      OP_AUIPC: return pc + b;
      OP_ADD:   return a + b;
      OP_SUB:   return a - b;
      OP_SLT:   return {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:  return {{(XLEN-1){1'b0}}, (a < b)};
      OP_XOR:   return a ^ b;
      OP_OR:    return a | b;
      OP_AND:   return a & b;
      OP_SLL:   return a << sh;
      OP_SRL:   return a >> sh;
      OP_SRA:   return $signed(a) >>> sh;
      default:  return '0;
    endcase
  endfunction

  assign bus.in_ready   = !rst && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_zero   = out_zero_q;
  assign accept_s       = bus.in_valid && bus.in_ready && !bus.flush;

  // Decode the incoming op: immediate result, special cases and engine setup
  always_comb begin
    is_mop_s      = (bus.alu_op[4:3] == 2'b10);
    is_div_s      = is_mop_s && bus.alu_op[2];
    sdiv_s        = is_div_s && !bus.alu_op[0];
    special_s     = 1'b0;
    special_res_s = '0;
    if (is_div_s && (bus.b == '0)) begin
      special_s     = 1'b1;
      special_res_s = bus.alu_op[1] ? bus.a : '1;
    end else if (sdiv_s && (bus.a == MOST_NEG) && (bus.b == '1)) begin
      special_s     = 1'b1;
      special_res_s = bus.alu_op[1] ? '0 : bus.a;
    end else begin
      special_s     = 1'b0;
      special_res_s = '0;
    end
    imm_res_s = is_mop_s ? special_res_s : base_alu(bus.alu_op, bus.a, bus.b, bus.pc);
    mag_a_s   = (sdiv_s && bus.a[XLEN-1]) ? -bus.a : bus.a;
    mag_b_s   = (sdiv_s && bus.b[XLEN-1]) ? -bus.b : bus.b;
    if (is_div_s) begin
      // Remainder:quotient pair starts as 0:|A|; mplier holds |B| throughout
      setup_acc_s    = {{XLEN{1'b0}}, mag_a_s};
      setup_mcand_s  = '0;
      setup_mplier_s = mag_b_s;
      setup_mcorr_s  = 1'b0;
      setup_qneg_s   = sdiv_s && (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
      setup_rneg_s   = sdiv_s && bus.a[XLEN-1];
    end else begin
      // A extended per variant; B's extension bit (weight -2^XLEN) becomes a final correction
      setup_acc_s    = '0;
      setup_mcand_s  = (bus.alu_op[1:0] != 2'b11) ? {{XLEN{bus.a[XLEN-1]}}, bus.a}
                                                  : {{XLEN{1'b0}}, bus.a};
      setup_mplier_s = bus.b;
      setup_mcorr_s  = !bus.alu_op[1] && bus.b[XLEN-1];
      setup_qneg_s   = 1'b0;
      setup_rneg_s   = 1'b0;
    end
  end

  // One multiply/divide iteration plus final sign fix-up and result select
  always_comb begin
    div_top_s = acc_q[2*XLEN-1:XLEN-1];
    div_ge_s  = div_top_s[XLEN] || (div_top_s[XLEN-1:0] >= mplier_q);
    div_rem_s = div_ge_s ? (div_top_s[XLEN-1:0] - mplier_q) : div_top_s[XLEN-1:0];
    if (op_q[2]) begin
      iter_s = {div_rem_s, acc_q[XLEN-2:0], div_ge_s};
    end else begin
      iter_s = acc_q + (mplier_q[0] ? mcand_q : '0);
    end
    prod_s = iter_s - (mcorr_q ? {mcand_q[2*XLEN-2:0], 1'b0} : '0);
    quo_s  = qneg_q ? -iter_s[XLEN-1:0] : iter_s[XLEN-1:0];
    rem_s  = rneg_q ? -iter_s[2*XLEN-1:XLEN] : iter_s[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                      final_res_s = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_res_s = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             final_res_s = quo_s;
      OP_REM, OP_REMU:             final_res_s = rem_s;
      default:                     final_res_s = '0;
    endcase
  end

  // FSM next state and datapath register updates; flush overrides everything
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_d         = op_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    mcorr_d      = mcorr_q;
    qneg_d       = qneg_q;
    rneg_d       = rneg_q;
    out_result_d = out_result_q;
    out_zero_d   = out_zero_q;
    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept_s) begin
            op_d     = bus.alu_op;
            cnt_d    = '0;
            acc_d    = setup_acc_s;
            mcand_d  = setup_mcand_s;
            mplier_d = setup_mplier_s;
            mcorr_d  = setup_mcorr_s;
            qneg_d   = setup_qneg_s;
            rneg_d   = setup_rneg_s;
            if (is_mop_s && !special_s) begin
              state_d = CALC;
            end else begin
              state_d      = DONE;
              out_result_d = imm_res_s;
              out_zero_d   = (imm_res_s == '0);
            end
          end else if ((state_q == DONE) && bus.out_ready) begin
            state_d = IDLE;
          end else begin
            state_d = state_q;
          end
        end
        CALC: begin
          acc_d = iter_s;
          if (!op_q[2]) begin
            mcand_d  = {mcand_q[2*XLEN-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[XLEN-1:1]};
          end else begin
            mcand_d  = mcand_q;
            mplier_d = mplier_q;
          end
          if (cnt_q == CNT_LAST) begin
            state_d      = DONE;
            cnt_d        = '0;
            out_result_d = final_res_s;
            out_zero_d   = (final_res_s == '0);
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_q         <= '0;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      mcorr_q      <= 1'b0;
      qneg_q       <= 1'b0;
      rneg_q       <= 1'b0;
      out_result_q <= '0;
      out_zero_q   <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      mcorr_q      <= mcorr_d;
      qneg_q       <= qneg_d;
      rneg_q       <= rneg_d;
      out_result_q <= out_result_d;
      out_zero_q   <= out_zero_d;
      out_valid_q  <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed plus random bench for alu_mdu against a plain-arithmetic reference.
module tb_alu_mdu;
  localparam int XLEN = 32;

  localparam logic [4:0] OP_NOP = 5'h00, OP_LUI = 5'h01, OP_AUIPC = 5'h02, OP_ADD = 5'h03;
  localparam logic [4:0] OP_SUB = 5'h04, OP_SLT = 5'h05, OP_SLTU = 5'h06, OP_XOR = 5'h07;
  localparam logic [4:0] OP_OR = 5'h08, OP_AND = 5'h09, OP_SLL = 5'h0A, OP_SRL = 5'h0B;
  localparam logic [4:0] OP_SRA = 5'h0C, OP_MUL = 5'h10, OP_MULH = 5'h11, OP_MULHSU = 5'h12;
  localparam logic [4:0] OP_MULHU = 5'h13, OP_DIV = 5'h14, OP_DIVU = 5'h15, OP_REM = 5'h16;
  localparam logic [4:0] OP_REMU = 5'h17;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  logic seen;
  int   k;
  logic [31:0] ra, rb, rpc;
  logic [4:0]  op_tab [22] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
                               5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h10, 5'h11, 5'h12,
                               5'h13, 5'h14, 5'h15, 5'h16, 5'h17, 5'h1D};

  alu_mdu_if #(.XLEN(XLEN)) bus ();
  alu_mdu #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] pc);
    longint      p;
    logic [63:0] u;
    case (op)
      OP_NOP:    return a;
      OP_LUI:    return b;
      OP_AUIPC:  return pc + b;
      OP_ADD:    return a + b;
      OP_SUB:    return a - b;
      OP_SLT:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU:   return (a < b) ? 32'd1 : 32'd0;
      OP_XOR:    return a ^ b;
      OP_OR:     return a | b;
      OP_AND:    return a & b;
      OP_SLL:    return a << b[4:0];
      OP_SRL:    return a >> b[4:0];
      OP_SRA:    return $signed(a) >>> b[4:0];
      OP_MUL, OP_MULH: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return (op == OP_MUL) ? p[31:0] : p[63:32];
      end
      OP_MULHSU: begin
        p = longint'($signed(a)) * longint'({32'd0, b});
        return p[63:32];
      end
      OP_MULHU: begin
        u = {32'd0, a} * {32'd0, b};
        return u[63:32];
      end
      OP_DIV, OP_REM: begin
        if (b == 32'd0) return (op == OP_DIV) ? 32'hFFFF_FFFF : a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return (op == OP_DIV) ? a : 32'd0;
        if (op == OP_DIV) p = longint'($signed(a)) / longint'($signed(b));
        else              p = longint'($signed(a)) % longint'($signed(b));
        return p[31:0];
      end
      OP_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      OP_REMU:   return (b == 32'd0) ? a : a % b;
      default:   return 32'd0;
    endcase
  endfunction

  // Cycles from accept to a visible result: 1 for single-cycle work, XLEN+1 otherwise
  function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < OP_MUL || op > OP_REMU) return 1;
    if (op >= OP_DIV && b == 32'd0) return 1;
    if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc);
    logic [31:0] exp;
    int exp_lat;
    int lat;
    exp     = ref_model(op, a, b, pc);
    exp_lat = ref_lat(op, a, b);
    @(negedge clk);
    chk({tag, ".rdy"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1; bus.alu_op = op; bus.a = a; bus.b = b; bus.pc = pc;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.alu_op = 5'($urandom);
    bus.a = $urandom; bus.b = $urandom; bus.pc = $urandom;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      if (lat == 16) chk({tag, ".busy"}, {30'd0, bus.in_ready, bus.out_valid}, 32'd0);
      @(negedge clk);
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".res"}, bus.out_result, exp);
    chk({tag, ".zero"}, {31'd0, bus.out_zero}, {31'd0, (exp == 32'd0)});
  endtask

  initial begin
    rst = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.alu_op = 5'd0; bus.a = 32'd0; bus.b = 32'd0; bus.pc = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst.rdy", {31'd0, bus.in_ready}, 32'd0);
    chk("rst.valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst.res", bus.out_result, 32'd0);
    chk("rst.zero", {31'd0, bus.out_zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.rdy1", {31'd0, bus.in_ready}, 32'd1);

    run_op("add0", OP_ADD, 32'd5, 32'hFFFF_FFFB, 32'd0);
    run_op("sll", OP_SLL, 32'd1, 32'h21, 32'd0);
    run_op("auipc", OP_AUIPC, 32'd0, 32'h0000_1000, 32'h0000_0400);
    run_op("sra", OP_SRA, 32'h8000_0000, 32'd4, 32'd0);
    run_op("mul", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'd0);
    run_op("mulh", OP_MULH, 32'h8000_0000, 32'h8000_0000, 32'd0);
    run_op("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
    run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0);
    run_op("rem", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'd0);
    run_op("divu", OP_DIVU, 32'hFFFF_FFFE, 32'd3, 32'd0);
    run_op("remu", OP_REMU, 32'd100, 32'd7, 32'd0);
    run_op("div0", OP_DIV, 32'd9, 32'd0, 32'd0);
    run_op("rem0", OP_REM, 32'd9, 32'd0, 32'd0);
    run_op("divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_op("removf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // Flush ten cycles into a divide
    @(negedge clk);
    bus.in_valid = 1'b1; bus.alu_op = OP_DIV; bus.a = 32'd1000; bus.b = 32'd7;
    @(negedge clk);
    bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 1; i < 10; i++) begin seen = seen | bus.out_valid; @(negedge clk); end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush.rdy", {31'd0, bus.in_ready}, 32'd1);
    for (int i = 0; i < 40; i++) begin seen = seen | bus.out_valid; @(negedge clk); end
    chk("flush.nov", {31'd0, seen}, 32'd0);
    run_op("flush.add", OP_ADD, 32'd2, 32'd3, 32'd0);

    // Flush together with out_ready and a pending op in DONE
    run_op("fd.or", OP_OR, 32'h0000_00F0, 32'h0000_0F00, 32'd0);
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.alu_op = OP_ADD; bus.a = 32'd1; bus.b = 32'd1;
    @(negedge clk);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("fd.valid", {31'd0, bus.out_valid}, 32'd0);
    chk("fd.hold", bus.out_result, 32'h0000_0FF0);
    chk("fd.rdy", {31'd0, bus.in_ready}, 32'd1);

    // Backpressure on a finished multiply, then release with an add queued
    bus.out_ready = 1'b0;
    run_op("bp.mul", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.res", bus.out_result, 32'hFFFF_FFEB);
      chk("bp.hs", {30'd0, bus.out_valid, bus.in_ready}, 32'd2);
    end
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.alu_op = OP_ADD; bus.a = 32'd2; bus.b = 32'd3;
    #1;
    chk("bp.rdy", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp.next.v", {31'd0, bus.out_valid}, 32'd1);
    chk("bp.next.res", bus.out_result, 32'd5);

    // Reset in the middle of a multiply
    @(negedge clk);
    bus.in_valid = 1'b1; bus.alu_op = OP_MULHU; bus.a = 32'h1234_5678; bus.b = 32'h9ABC_DEF0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin seen = seen | bus.out_valid; @(negedge clk); end
    chk("rstmid.nov", {31'd0, seen}, 32'd0);
    chk("rstmid.res", bus.out_result, 32'd0);

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      k   = int'($urandom_range(0, 21));
      ra  = $urandom;
      rb  = $urandom;
      rpc = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 7) == 1) rb = {27'd0, 5'($urandom)};
      run_op("rnd", op_tab[k], ra, rb, rpc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
